// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: access sizes,
// memory geometry, requester ids and the response tag carried through the read pipe.
package imem_arbiter_pkg;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

    localparam int unsigned MEM_BYTES = 8192;
    localparam int          RD_LAT    = 2;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
        logic  werr;
    } rsp_tag_t;

    function automatic logic [32:0] access_bytes(input logic [2:0] wsz);
        case (wsz)
            ACCESS_SZ_BYTE: access_bytes = 33'd1;
            ACCESS_SZ_HALF: access_bytes = 33'd2;
            default:        access_bytes = 33'd4;
        endcase
    endfunction

    // Partial overlap of a word read with the buffered write; 33-bit so ranges near 2^32 do not wrap.
    function automatic logic rd_hazard(input logic [31:0] raddr,
                                       input logic [31:0] waddr,
                                       input logic [2:0]  wsz);
        logic [32:0] rlo;
        logic [32:0] wlo;
        rlo = {1'b0, raddr};
        wlo = {1'b0, waddr};
        rd_hazard = (rlo < wlo + access_bytes(wsz)) && (wlo < rlo + 33'd4) && (raddr != waddr);
    endfunction

endpackage

// File: rtl/imem_rsp_tracker.sv
// Fixed-depth tag pipe that follows each read (or failed write) through the
// memory latency and presents the tag whose response is due this cycle.
module imem_rsp_tracker
    import imem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  rsp_tag_t i_push,
    output rsp_tag_t o_pop
);

    rsp_tag_t r_pipe [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_push;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_pop = r_pipe[RD_LAT-1];

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter between fetch and data ports for the shared memory, with
// partial-overlap read-after-write stall, write-field hold and response routing.
module imem_arbiter
    import imem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        o_f_gnt,
    output logic        o_f_rvalid,
    output logic [31:0] o_f_rdata,
    output logic        o_f_err,

    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [2:0]  i_d_wsz,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,

    output logic        o_mem_re,
    output logic [31:0] o_mem_raddr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_waddr,
    output logic [31:0] o_mem_wdata,
    output logic [2:0]  o_mem_wsz,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_hit
);

    port_t       r_rr;
    logic        r_wr_last;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic [2:0]  r_wsz;

    logic        w_f_haz;
    logic        w_d_haz;
    logic        w_f_ok;
    logic        w_d_ok;
    logic        w_f_win;
    logic        w_d_win;
    logic        w_d_rd;
    logic        w_mem_we;
    logic        w_d_oor;
    rsp_tag_t    w_push;
    rsp_tag_t    w_pop;
    logic        w_pop_live;

    // The stall only exists in the single cycle after a write grant.
    assign w_f_haz = r_wr_last & rd_hazard(i_f_addr, r_waddr, r_wsz);
    assign w_d_haz = r_wr_last & ~i_d_we & rd_hazard(i_d_addr, r_waddr, r_wsz);

    assign w_f_ok  = rst_n & i_f_req & ~w_f_haz;
    assign w_d_ok  = rst_n & i_d_req & ~w_d_haz;
    assign w_f_win = w_f_ok & (~w_d_ok | (r_rr == PORT_F));
    assign w_d_win = w_d_ok & ~w_f_win;

    assign w_d_rd   = w_d_win & ~i_d_we;
    assign w_mem_we = w_d_win & i_d_we;
    assign w_d_oor  = i_d_addr >= MEM_BYTES;

    assign o_f_gnt     = w_f_win;
    assign o_d_gnt     = w_d_win;
    assign o_mem_re    = w_f_win | w_d_rd;
    assign o_mem_raddr = w_f_win ? i_f_addr : (w_d_rd ? i_d_addr : 32'd0);
    assign o_mem_we    = w_mem_we;
    assign o_mem_waddr = w_mem_we ? i_d_addr  : r_waddr;
    assign o_mem_wdata = w_mem_we ? i_d_wdata : r_wdata;
    assign o_mem_wsz   = w_mem_we ? i_d_wsz   : r_wsz;

    // Pointer moves to the loser only on contended grants, so a stalled port keeps its turn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr      <= PORT_F;
            r_wr_last <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wsz     <= '0;
        end else begin
            r_wr_last <= w_mem_we;
            if (w_mem_we) begin
                r_waddr <= i_d_addr;
                r_wdata <= i_d_wdata;
                r_wsz   <= i_d_wsz;
            end
            if (i_f_req && i_d_req && (w_f_win || w_d_win)) begin
                r_rr <= w_f_win ? PORT_D : PORT_F;
            end
        end
    end

    assign w_push.valid = w_f_win | w_d_rd | (w_mem_we & w_d_oor);
    assign w_push.port  = w_d_win ? PORT_D : PORT_F;
    assign w_push.werr  = w_mem_we;

    imem_rsp_tracker u_rsp_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .o_pop  (w_pop)
    );

    assign w_pop_live = rst_n & w_pop.valid;

    assign o_f_rvalid = w_pop_live & (w_pop.port == PORT_F);
    assign o_f_err    = o_f_rvalid & ~i_mem_hit;
    assign o_f_rdata  = o_f_rvalid ? i_mem_rdata : 32'd0;

    // A failed write carries no data; the memory returns nothing for it.
    assign o_d_rvalid = w_pop_live & (w_pop.port == PORT_D);
    assign o_d_err    = o_d_rvalid & (w_pop.werr | ~i_mem_hit);
    assign o_d_rdata  = (o_d_rvalid & ~w_pop.werr) ? i_mem_rdata : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a behavioural memory with a one-entry write buffer,
// a reference byte array and per-port response scoreboards.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        fReq, dReq, dWe;
    logic [31:0] fAddr, dAddr, dWdata;
    logic [2:0]  dWsz;
    logic        fGnt, fRvalid, fErr, dGnt, dRvalid, dErr;
    logic [31:0] fRdata, dRdata;
    logic        memRe, memWe, memHit;
    logic [31:0] memRaddr, memWaddr, memWdata, memRdata;
    logic [2:0]  memWsz;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t fQ[$];
    exp_t dQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   monEn = 0;
    bit   loaded = 0;

    logic [7:0]  memArr [MEM_BYTES];
    logic [7:0]  refArr [MEM_BYTES];
    logic        bufValid = 1'b0;
    logic [31:0] bufAddr = '0, bufData = '0;
    logic [2:0]  bufSz = '0;
    logic [31:0] p1Data = '0, p2Data = '0;
    logic        p1Hit = 1'b1, p2Hit = 1'b1;

    imem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_f_req(fReq), .i_f_addr(fAddr), .o_f_gnt(fGnt),
        .o_f_rvalid(fRvalid), .o_f_rdata(fRdata), .o_f_err(fErr),
        .i_d_req(dReq), .i_d_we(dWe), .i_d_addr(dAddr), .i_d_wdata(dWdata), .i_d_wsz(dWsz),
        .o_d_gnt(dGnt), .o_d_rvalid(dRvalid), .o_d_rdata(dRdata), .o_d_err(dErr),
        .o_mem_re(memRe), .o_mem_raddr(memRaddr),
        .o_mem_we(memWe), .o_mem_waddr(memWaddr), .o_mem_wdata(memWdata), .o_mem_wsz(memWsz),
        .i_mem_rdata(memRdata), .i_mem_hit(memHit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] initByte(input int a);
        return 8'(a) ^ 8'h5A ^ 8'(a >> 8);
    endfunction

    function automatic int szBytes(input logic [2:0] sz);
        if (sz == ACCESS_SZ_BYTE) return 1;
        if (sz == ACCESS_SZ_HALF) return 2;
        return 4;
    endfunction

    // Memory: 2-cycle read, write buffered for one cycle, forwards only on exact address match.
    always @(posedge clk) begin : memModel
        logic [31:0] word;
        if (!loaded) begin
            for (int a = 0; a < int'(MEM_BYTES); a++) memArr[a] = initByte(a);
            loaded = 1'b1;
        end
        word = '0;
        if (memRe && memRaddr <= MEM_BYTES - 4) begin
            for (int k = 0; k < 4; k++) word[8*k +: 8] = memArr[int'(memRaddr) + k];
            if (bufValid && bufAddr == memRaddr)
                for (int k = 0; k < szBytes(bufSz); k++) word[8*k +: 8] = bufData[8*k +: 8];
        end
        p1Data <= word;
        p1Hit  <= memRe ? (memRaddr < MEM_BYTES) : 1'b1;
        p2Data <= p1Data;
        p2Hit  <= p1Hit;
        if (bufValid && bufAddr < MEM_BYTES)
            for (int k = 0; k < szBytes(bufSz); k++)
                if (int'(bufAddr) + k < int'(MEM_BYTES)) memArr[int'(bufAddr) + k] = bufData[8*k +: 8];
        bufValid <= memWe;
        bufAddr  <= memWaddr;
        bufData  <= memWdata;
        bufSz    <= memWsz;
    end

    assign memRdata = p2Data;
    assign memHit   = p2Hit;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dd, input logic [2:0] dsz);
        @(posedge clk);
        #1;
        fReq = fr; fAddr = fa; dReq = dr; dWe = dw; dAddr = da; dWdata = dd; dWsz = dsz;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic expectGrant(input string tag, input logic fg, input logic dg);
        checkOutput({tag, " f_gnt"}, fGnt, fg);
        checkOutput({tag, " d_gnt"}, dGnt, dg);
    endtask

    task automatic expectRead(input port_t port, input logic [31:0] addr);
        exp_t e;
        e.due  = cyc + 2;
        e.data = '0;
        e.err  = addr >= MEM_BYTES;
        if (!e.err)
            for (int k = 0; k < 4; k++) e.data[8*k +: 8] = refArr[int'(addr) + k];
        if (port == PORT_F) fQ.push_back(e);
        else dQ.push_back(e);
    endtask

    task automatic expectWerr();
        exp_t e;
        e.due = cyc + 2; e.data = '0; e.err = 1'b1;
        dQ.push_back(e);
    endtask

    task automatic refWrite(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sz);
        if (addr < MEM_BYTES)
            for (int k = 0; k < szBytes(sz); k++) refArr[int'(addr) + k] = data[8*k +: 8];
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, " f_gnt"}, fGnt, 1'b0);
        checkOutput({tag, " d_gnt"}, dGnt, 1'b0);
        checkOutput({tag, " f_rvalid"}, fRvalid, 1'b0);
        checkOutput({tag, " d_rvalid"}, dRvalid, 1'b0);
        checkOutput({tag, " f_err"}, fErr, 1'b0);
        checkOutput({tag, " d_err"}, dErr, 1'b0);
        checkOutput({tag, " f_rdata"}, fRdata, 32'd0);
        checkOutput({tag, " d_rdata"}, dRdata, 32'd0);
        checkOutput({tag, " mem_re"}, memRe, 1'b0);
        checkOutput({tag, " mem_we"}, memWe, 1'b0);
    endtask

    // Every cycle each port either owes exactly the queued response or must stay silent.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (monEn) begin
            if (fQ.size() != 0 && fQ[0].due == cyc) begin
                e = fQ.pop_front();
                checkOutput("f_rvalid", fRvalid, 1'b1);
                checkOutput("f_rdata", fRdata, e.data);
                checkOutput("f_err", fErr, e.err);
            end else begin
                checkOutput("f_rvalid idle", fRvalid, 1'b0);
            end
            if (dQ.size() != 0 && dQ[0].due == cyc) begin
                e = dQ.pop_front();
                checkOutput("d_rvalid", dRvalid, 1'b1);
                checkOutput("d_rdata", dRdata, e.data);
                checkOutput("d_err", dErr, e.err);
            end else begin
                checkOutput("d_rvalid idle", dRvalid, 1'b0);
            end
        end
    end

    initial begin
        for (int a = 0; a < int'(MEM_BYTES); a++) refArr[a] = initByte(a);
        rst_n = 1'b0;
        fReq = 0; fAddr = 0; dReq = 0; dWe = 0; dAddr = 0; dWdata = 0; dWsz = 0;

        idle();
        checkAllIdle("reset");
        checkOutput("reset mem_waddr", memWaddr, 32'd0);
        idle();
        idle();
        rst_n = 1'b1;
        monEn = 1'b1;

        // Contended reads alternate starting with fetch.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'd0, 3'd0);
            expectGrant("rr", (i % 2) == 0, (i % 2) == 1);
            checkOutput("rr mem_re", memRe, 1'b1);
            checkOutput("rr mem_raddr", memRaddr, (i % 2) == 0 ? 32'h100 : 32'h200);
            expectRead((i % 2) == 0 ? PORT_F : PORT_D, (i % 2) == 0 ? 32'h100 : 32'h200);
        end

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'h11223344, ACCESS_SZ_WORD);
        expectGrant("wr40", 1'b0, 1'b1);
        checkOutput("wr40 mem_we", memWe, 1'b1);
        checkOutput("wr40 mem_waddr", memWaddr, 32'h40);
        refWrite(32'h40, 32'h11223344, ACCESS_SZ_WORD);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("exact fwd", 1'b1, 1'b0);
        expectRead(PORT_F, 32'h40);

        // Partial overlap stalls fetch; data read proceeds, fetch keeps its turn.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hCAFEBABE, ACCESS_SZ_WORD);
        expectGrant("wr40b", 1'b0, 1'b1);
        refWrite(32'h40, 32'hCAFEBABE, ACCESS_SZ_WORD);
        applyStimulus(1'b1, 32'h42, 1'b1, 1'b0, 32'h300, 32'd0, 3'd0);
        expectGrant("stall f42", 1'b0, 1'b1);
        checkOutput("stall mem_raddr", memRaddr, 32'h300);
        expectRead(PORT_D, 32'h300);
        applyStimulus(1'b1, 32'h42, 1'b1, 1'b0, 32'h304, 32'd0, 3'd0);
        expectGrant("keep turn", 1'b1, 1'b0);
        expectRead(PORT_F, 32'h42);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h304, 32'd0, 3'd0);
        expectGrant("d304", 1'b0, 1'b1);
        expectRead(PORT_D, 32'h304);

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h80, 32'h0000BEEF, ACCESS_SZ_HALF);
        expectGrant("wr80", 1'b0, 1'b1);
        refWrite(32'h80, 32'h0000BEEF, ACCESS_SZ_HALF);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h7E, 32'd0, 3'd0);
        expectGrant("stall d7e", 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h7E, 32'd0, 3'd0);
        expectGrant("d7e", 1'b0, 1'b1);
        expectRead(PORT_D, 32'h7E);

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h90, 32'h00000055, ACCESS_SZ_BYTE);
        expectGrant("wr90", 1'b0, 1'b1);
        refWrite(32'h90, 32'h55, ACCESS_SZ_BYTE);
        applyStimulus(1'b1, 32'h91, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("adjacent f91", 1'b1, 1'b0);
        expectRead(PORT_F, 32'h91);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h90, 32'h00000066, ACCESS_SZ_BYTE);
        expectGrant("wr90b", 1'b0, 1'b1);
        refWrite(32'h90, 32'h66, ACCESS_SZ_BYTE);
        applyStimulus(1'b1, 32'h8D, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("stall f8d", 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8D, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("f8d", 1'b1, 1'b0);
        expectRead(PORT_F, 32'h8D);

        // Overlap near the top of the address space must not wrap.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h12345678, ACCESS_SZ_WORD);
        expectGrant("wr top", 1'b0, 1'b1);
        expectWerr();
        applyStimulus(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("stall top", 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("f top", 1'b1, 1'b0);
        expectRead(PORT_F, 32'hFFFFFFFC);

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h2000, 32'd0, 3'd0);
        expectGrant("rd oor", 1'b0, 1'b1);
        expectRead(PORT_D, 32'h2000);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h3000, 32'hDEADBEEF, ACCESS_SZ_WORD);
        expectGrant("wr oor", 1'b0, 1'b1);
        checkOutput("wr oor mem_we", memWe, 1'b1);
        expectWerr();
        idle();

        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'h000000AB, ACCESS_SZ_BYTE);
        expectGrant("wr10", 1'b0, 1'b1);
        refWrite(32'h10, 32'hAB, ACCESS_SZ_BYTE);
        for (int i = 0; i < 5; i++) begin
            idle();
            checkOutput("hold mem_we", memWe, 1'b0);
            checkOutput("hold mem_waddr", memWaddr, 32'h10);
            checkOutput("hold mem_wdata", memWdata, 32'hAB);
            checkOutput("hold mem_wsz", memWsz, ACCESS_SZ_BYTE);
        end
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("f10", 1'b1, 1'b0);
        expectRead(PORT_F, 32'h10);
        idle();
        idle();
        idle();

        // Reset for one cycle with reads in flight: their responses must vanish.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        expectGrant("pre-reset", 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        rst_n = 1'b0;
        #1;
        checkAllIdle("mid reset");
        idle();
        rst_n = 1'b1;
        checkOutput("post reset mem_waddr", memWaddr, 32'd0);
        checkOutput("post reset mem_wsz", memWsz, 3'd0);
        idle();

        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'd0, 3'd0);
        expectGrant("rr after reset", 1'b1, 1'b0);
        expectRead(PORT_F, 32'h100);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'd0, 3'd0);
        expectGrant("d after reset", 1'b0, 1'b1);
        expectRead(PORT_D, 32'h200);

        repeat (4) idle();
        checkOutput("f scoreboard empty", fQ.size(), 32'd0);
        checkOutput("d scoreboard empty", dQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
